// File: rtl/fir_coef_loader.sv
// +----------------------------------------------------------------------------+
// | fir_coef_loader                                                              |
// | Ping-pong coefficient banks streamed into the fir_filter serial config port. |
// | Optional build macro: COEF_SYMMETRIC_EN (half-depth mirrored banks).         |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_coef_loader #(
   parameter int LEN    = 21,
   parameter int CW     = 25,
   parameter int SETTLE = 24,
   localparam int AW    = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          wr_en_i,
   input  logic          wr_bank_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [CW-1:0] wr_data_i,
   output logic          wr_err_o,
   input  logic          load_req_i,
   input  logic          load_bank_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          active_bank_o,
   output logic [CW-1:0] cfg_din_o,
   output logic          cfg_ce_o,
   output logic          hold_o
);

`ifdef COEF_SYMMETRIC_EN
   localparam int DEPTH = (LEN + 1) / 2;
`else
   localparam int DEPTH = LEN;
`endif
   localparam int MAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTMAX = (LEN > SETTLE) ? LEN : SETTLE;
   localparam int CNTW   = $clog2(CNTMAX + 1);

   localparam logic [CNTW-1:0] STREAM_END = CNTW'(LEN);
   localparam logic [CNTW-1:0] SETTLE_END = CNTW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [AW:0]     DEPTH_LIM  = (AW + 1)'(DEPTH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            bank_q, bank_d;
   logic            pend_q, pend_d;
   logic            pend_bank_q, pend_bank_d;
   logic            rd_vld_q;
   logic [CW-1:0]   rd_data_q;
   logic            busy_q, hold_q, done_q, active_q, wr_err_q, cfg_ce_q;
   logic [CW-1:0]   cfg_din_q;

   logic [CW-1:0]   mem_q [0:1][0:DEPTH-1];

   logic            w_accept, w_acc_bank, w_locked, w_wr_ok, w_rd_en;
   logic [AW-1:0]   w_beat, w_rd_full;
   logic [MAW-1:0]  w_rd_addr;

   // A load from IDLE takes the live request first, else the pending one.
   assign w_accept   = (state_q == ST_IDLE) && (load_req_i || pend_q);
   assign w_acc_bank = load_req_i ? load_bank_i : pend_bank_q;

   assign w_locked = ((state_q != ST_IDLE) && (wr_bank_i == bank_q)) ||
                     (w_accept && (wr_bank_i == w_acc_bank));
   assign w_wr_ok  = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_LIM) && !w_locked;

   // The final STREAM count (cnt == LEN) is a drain cycle with no read.
   assign w_rd_en = (state_q == ST_STREAM) && (cnt_q != STREAM_END);
   assign w_beat  = cnt_q[AW-1:0];

`ifdef COEF_SYMMETRIC_EN
   localparam logic [AW-1:0] LAST_A = AW'(LEN - 1);
   logic [AW-1:0] w_mirror;
   logic          w_unused_hi;
   assign w_mirror    = LAST_A - w_beat;
   assign w_rd_full   = (w_beat <= w_mirror) ? w_beat : w_mirror;
   assign w_unused_hi = ^w_rd_full;
`else
   assign w_rd_full = w_beat;
`endif
   assign w_rd_addr = w_rd_full[MAW-1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bank_d      = bank_q;
      pend_d      = pend_q;
      pend_bank_d = pend_bank_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d = ST_STREAM;
               cnt_d   = '0;
               bank_d  = w_acc_bank;
               pend_d  = 1'b0;
            end
         end
         ST_STREAM: begin
            if (cnt_q == STREAM_END) begin
               cnt_d   = '0;
               state_d = (SETTLE == 0) ? ST_IDLE : ST_SETTLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_END) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_q != ST_IDLE) && load_req_i) begin
         pend_d      = 1'b1;
         pend_bank_d = load_bank_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr_ok) begin
         mem_q[wr_bank_i][wr_addr_i[MAW-1:0]] <= wr_data_i;
      end
      if (w_rd_en) begin
         rd_data_q <= mem_q[bank_q][w_rd_addr];
      end
   end

   // Status outputs trail the state by one cycle; IDLE with busy_q set is the done cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bank_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_bank_q <= 1'b0;
         rd_vld_q    <= 1'b0;
         cfg_ce_q    <= 1'b0;
         cfg_din_q   <= '0;
         busy_q      <= 1'b0;
         hold_q      <= 1'b0;
         done_q      <= 1'b0;
         active_q    <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bank_q      <= bank_d;
         pend_q      <= pend_d;
         pend_bank_q <= pend_bank_d;
         rd_vld_q    <= w_rd_en;
         cfg_ce_q    <= rd_vld_q;
         cfg_din_q   <= rd_vld_q ? rd_data_q : '0;
         hold_q      <= (state_q != ST_IDLE);
         busy_q      <= (state_q != ST_IDLE) || pend_q;
         done_q      <= (state_q == ST_IDLE) && busy_q;
         if ((state_q == ST_IDLE) && busy_q) begin
            active_q <= bank_q;
         end
         wr_err_q    <= wr_en_i && !w_wr_ok;
      end
   end

   assign wr_err_o      = wr_err_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign active_bank_o = active_q;
   assign cfg_din_o     = cfg_din_q;
   assign cfg_ce_o      = cfg_ce_q;
   assign hold_o        = hold_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
// +----------------------------------------------------------------------------+
// | tb_fir_coef_loader                                                           |
// | Directed checks of fir_coef_loader; honours COEF_SYMMETRIC_EN if defined.    |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fir_coef_loader;
   localparam int LEN    = 21;
   localparam int CW     = 25;
   localparam int SETTLE = 24;
   localparam int AW     = $clog2(LEN);
`ifdef COEF_SYMMETRIC_EN
   localparam int DEPTH = (LEN + 1) / 2;
`else
   localparam int DEPTH = LEN;
`endif
   localparam int TOT = LEN + SETTLE + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0, wr_bank = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [CW-1:0] wr_data = '0;
   logic          load_req = 1'b0, load_bank = 1'b0;
   logic          wr_err, busy, done, active_bank, cfg_ce, hold;
   logic [CW-1:0] cfg_din;

   logic [CW-1:0] mdl [0:1][0:LEN-1];
   int            n_vec = 0;
   int            n_err = 0;

   fir_coef_loader #(.LEN(LEN), .CW(CW), .SETTLE(SETTLE)) dut (
      .clk_i(clk), .reset_i(reset),
      .wr_en_i(wr_en), .wr_bank_i(wr_bank), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_err_o(wr_err),
      .load_req_i(load_req), .load_bank_i(load_bank),
      .busy_o(busy), .done_o(done), .active_bank_o(active_bank),
      .cfg_din_o(cfg_din), .cfg_ce_o(cfg_ce), .hold_o(hold)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int beat_addr(input int i);
`ifdef COEF_SYMMETRIC_EN
      return (i < LEN - 1 - i) ? i : LEN - 1 - i;
`else
      return i;
`endif
   endfunction

   task automatic wr(input logic b, input int a, input logic [CW-1:0] d, input logic exp_err);
      wr_en = 1'b1; wr_bank = b; wr_addr = AW'(a); wr_data = d;
      tick();
      wr_en = 1'b0;
      chk($sformatf("wr_err b%0d a%0d", b, a), 32'(wr_err), 32'(exp_err));
      if (!exp_err) mdl[b][a] = d;
   endtask

   // Called at the accept cycle k (or later, from k+jstart-1); checks every cycle to done.
   task automatic seq_check(input logic bnk, input logic busy_at_done, input int jstart);
      logic          ce_e, hold_e, busy_e;
      logic [CW-1:0] din_e;
      for (int j = jstart; j <= TOT; j++) begin
         tick();
         ce_e   = (j >= 2) && (j <= LEN + 1);
         din_e  = ce_e ? mdl[bnk][beat_addr(j - 2)] : '0;
         hold_e = (j <= LEN + SETTLE + 1);
         busy_e = hold_e || busy_at_done;
         chk($sformatf("cfg_ce j%0d", j), 32'(cfg_ce), 32'(ce_e));
         chk($sformatf("cfg_din j%0d", j), 32'(cfg_din), 32'(din_e));
         chk($sformatf("hold j%0d", j), 32'(hold), 32'(hold_e));
         chk($sformatf("busy j%0d", j), 32'(busy), 32'(busy_e));
         chk($sformatf("done j%0d", j), 32'(done), 32'(j == TOT));
      end
      chk("active_bank", 32'(active_bank), 32'(bnk));
   endtask

   task automatic start_load(input logic b);
      load_req = 1'b1; load_bank = b;
      tick();
      load_req = 1'b0;
      chk("busy at accept", 32'(busy), 32'd0);
   endtask

   initial begin
      int waited;
      tick(); tick();
      reset = 1'b0;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst hold", 32'(hold), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst cfg_ce", 32'(cfg_ce), 32'd0);
      chk("rst cfg_din", 32'(cfg_din), 32'd0);
      chk("rst active", 32'(active_bank), 32'd0);
      chk("rst wr_err", 32'(wr_err), 32'd0);

      // Bank 0: impulse of 1.1; bank 1: ramp 1,2,3,...
      for (int a = 0; a < DEPTH; a++) wr(1'b0, a, (a == 0) ? 25'h08CCCCC : 25'h0, 1'b0);
      for (int a = 0; a < DEPTH; a++) wr(1'b1, a, CW'(a + 1), 1'b0);

      wr(1'b0, DEPTH, 25'h0005555, 1'b1);
      tick();
      chk("wr_err pulse end", 32'(wr_err), 32'd0);

      start_load(1'b0);
      seq_check(1'b0, 1'b0, 1);

      // Ping-pong: other bank writable while streaming, streamed bank locked.
      start_load(1'b0);
      wr(1'b1, 5, 25'h1FFFFFF, 1'b0);
      wr(1'b0, 3, 25'h0000123, 1'b1);
      waited = 0;
      while (!done && waited < 100) begin tick(); waited++; end
      chk("pingpong done seen", 32'(done), 32'd1);
      chk("pingpong active", 32'(active_bank), 32'd0);

      // Same-bank write in the accept cycle is rejected.
      load_req = 1'b1; load_bank = 1'b1;
      wr_en = 1'b1; wr_bank = 1'b1; wr_addr = '0; wr_data = 25'h0000777;
      tick();
      load_req = 1'b0; wr_en = 1'b0;
      chk("accept-cycle wr_err", 32'(wr_err), 32'd1);
      seq_check(1'b1, 1'b0, 1);

      // Pending: bank1 then bank0 while busy -> one follow-on bank0 load.
      load_req = 1'b1; load_bank = 1'b0;
      tick();
      load_bank = 1'b1;
      tick();
      load_bank = 1'b0;
      tick();
      load_req = 1'b0;
      seq_check(1'b0, 1'b1, 3);
      seq_check(1'b0, 1'b0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post-pend done", 32'(done), 32'd0);
         chk("post-pend busy", 32'(busy), 32'd0);
      end

      start_load(1'b1);
      seq_check(1'b1, 1'b0, 1);

      // Reset during beat 10 with a pending request queued.
      start_load(1'b0);
      tick(); tick();
      load_req = 1'b1; load_bank = 1'b1;
      tick();
      load_req = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("beat10 cfg_ce", 32'(cfg_ce), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst cfg_ce", 32'(cfg_ce), 32'd0);
      chk("midrst hold", 32'(hold), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst active", 32'(active_bank), 32'd0);
      for (int i = 0; i < 60; i++) begin
         tick();
         chk("after rst cfg_ce", 32'(cfg_ce), 32'd0);
         chk("after rst busy", 32'(busy), 32'd0);
         chk("after rst done", 32'(done), 32'd0);
      end
      start_load(1'b0);
      seq_check(1'b0, 1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
